btn_debounce_rpt: RTL and testbench

- Single-button conditioner that consumes the 1 ms clock-enable tick produced by the tick generator stage (100 MHz CLK, one-cycle CE every 100000 cycles).
- Synchronises a raw mechanical button input and debounces it in CE ticks.
- Emits a clean level plus one-cycle press, release and auto-repeat strobes for the downstream control/display logic.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_debounce_rpt_sync2.sv | 12 +
 rtl/btn_debounce_rpt.sv | 76 +++++++
 tb/tb_btn_debounce_rpt.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared widths, state encoding and default tick counts for the button conditioner.
package btn_pkg;
  localparam int CNT_W = 10;
  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RPT = 2'd2;
  localparam int DEB_MS = 20;
  localparam int HOLD_MS = 500;
  localparam int RPT_MS = 100;
  typedef enum logic [1:0] {
    RELEASED = ST_RELEASED,
    HOLD = ST_HOLD,
    RPT = ST_RPT
  } btn_state_e;
endpackage

// File: rtl/btn_debounce_rpt_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, cleared by reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk) ff_q <= rst ? 2'b00 : ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/btn_debounce_rpt.sv
// btn_debounce_rpt: synchronise and debounce one button in CE ticks; emit level, press, release and auto-repeat strobes.
module btn_debounce_rpt
  import btn_pkg::*;
#(
  parameter int DEB_TICKS = DEB_MS,
  parameter int HOLD_TICKS = HOLD_MS,
  parameter int REPEAT_TICKS = RPT_MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic BTN_IN,
  output logic BTN_LVL,
  output logic PRESS,
  output logic RELEASE,
  output logic REPEAT
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic s_in, accept, hit;
  logic lvl_q, lvl_d, press_q, press_d, release_q, release_d, repeat_q, repeat_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
  btn_state_e state_q, state_d;
  sync2 u_sync (.clk(CLK), .rst(RST), .d(BTN_IN), .q(s_in));
  always_comb begin
    accept = s_in != lvl_q && CE && dcnt_q == DEB_LAST;
    dcnt_d = (s_in == lvl_q || accept) ? '0 : CE ? dcnt_q + CNT_W'(1) : dcnt_q;
    lvl_d = accept ? s_in : lvl_q;
    press_d = accept && s_in;
    release_d = accept && !s_in;
  end
  // A release accepted in the same cycle as a repeat expiry takes priority.
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    repeat_d = 1'b0;
    hit = CE && hcnt_q == (state_q == HOLD ? HOLD_LAST : RPT_LAST);
    case (state_q)
      RELEASED: if (press_d) begin
        state_d = HOLD;
        hcnt_d = '0;
      end
      HOLD, RPT: if (release_d) state_d = RELEASED;
      else if (hit) begin
        repeat_d = 1'b1;
        hcnt_d = '0;
        state_d = RPT;
      end else if (CE) hcnt_d = hcnt_q + CNT_W'(1);
      default: state_d = RELEASED;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RELEASED;
      dcnt_q <= '0;
      hcnt_q <= '0;
      lvl_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q <= dcnt_d;
      hcnt_q <= hcnt_d;
      lvl_q <= lvl_d;
      press_q <= press_d;
      release_q <= release_d;
      repeat_q <= repeat_d;
    end
  end
  assign BTN_LVL = lvl_q;
  assign PRESS = press_q;
  assign RELEASE = release_q;
  assign REPEAT = repeat_q;
endmodule

// File: tb/tb_btn_debounce_rpt.sv
// tb_btn_debounce_rpt: directed plus random stimulus on two configurations, checked every cycle against a tick-level model.
module tb_btn_debounce_rpt;
  typedef struct packed {
    logic p0, p1, lvl, press, rel, rpt;
    int run, k;
  } mdl_t;
  logic clk = 1'b0, rst = 1'b1, ce_a = 1'b0, btn_a = 1'b0, btn_b = 1'b0;
  logic lvl_a, press_a, rel_a, rpt_a, lvl_b, press_b, rel_b, rpt_b;
  int n_cmp = 0, n_bad = 0, ph = 0;
  int c_pa = 0, c_ra = 0, c_rpa = 0, c_pb = 0;
  bit freeze = 1'b0;
  mdl_t ma, mb;
  always #5 clk = ~clk;
  btn_debounce_rpt #(.DEB_TICKS(4), .HOLD_TICKS(8), .REPEAT_TICKS(3)) dut_a (
    .CLK(clk), .RST(rst), .CE(ce_a), .BTN_IN(btn_a),
    .BTN_LVL(lvl_a), .PRESS(press_a), .RELEASE(rel_a), .REPEAT(rpt_a));
  btn_debounce_rpt #(.DEB_TICKS(1), .HOLD_TICKS(8), .REPEAT_TICKS(3)) dut_b (
    .CLK(clk), .RST(rst), .CE(1'b1), .BTN_IN(btn_b),
    .BTN_LVL(lvl_b), .PRESS(press_b), .RELEASE(rel_b), .REPEAT(rpt_b));
  // Level changes after deb consecutive differing ticks; repeats fire at k == hold, hold+rep, hold+2*rep, ... ticks after a press.
  function automatic mdl_t step(mdl_t m, logic r, logic ce, logic btn, int deb, int hold, int rep);
    mdl_t n;
    n = m;
    n.press = 1'b0;
    n.rel = 1'b0;
    n.rpt = 1'b0;
    if (r) return '0;
    n.p0 = btn;
    n.p1 = m.p0;
    if (m.p1 == m.lvl) n.run = 0;
    else if (ce) begin
      n.run = m.run + 1;
      if (n.run == deb) begin
        n.lvl = m.p1;
        n.run = 0;
        n.press = m.p1;
        n.rel = !m.p1;
      end
    end
    if (n.press) n.k = 0;
    else if (m.lvl && !n.rel && ce) begin
      n.k = m.k + 1;
      n.rpt = n.k == hold || (n.k > hold && (n.k - hold) % rep == 0);
    end
    return n;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc1();
    ce_a = !freeze && ph == 4;
    @(posedge clk);
    ma = step(ma, rst, ce_a, btn_a, 4, 8, 3);
    mb = step(mb, rst, 1'b1, btn_b, 1, 8, 3);
    #1;
    chk("a_lvl", 32'(lvl_a), 32'(ma.lvl));
    chk("a_press", 32'(press_a), 32'(ma.press));
    chk("a_release", 32'(rel_a), 32'(ma.rel));
    chk("a_repeat", 32'(rpt_a), 32'(ma.rpt));
    chk("b_lvl", 32'(lvl_b), 32'(mb.lvl));
    chk("b_press", 32'(press_b), 32'(mb.press));
    chk("b_release", 32'(rel_b), 32'(mb.rel));
    chk("b_repeat", 32'(rpt_b), 32'(mb.rpt));
    c_pa += int'(press_a);
    c_ra += int'(rel_a);
    c_rpa += int'(rpt_a);
    c_pb += int'(press_b);
    ph = (ph + 1) % 5;
  endtask
  task automatic clr();
    c_pa = 0;
    c_ra = 0;
    c_rpa = 0;
    c_pb = 0;
  endtask
  task automatic wait_pa(int lim);
    int i = 0;
    while (!press_a && i < lim) begin
      cyc1();
      i++;
    end
    chk("wait_press", 32'(press_a), 32'd1);
  endtask
  initial begin
    ma = '0;
    mb = '0;
    rst = 1'b1;
    btn_a = 1'b1;
    repeat (3) cyc1();
    rst = 1'b0;
    cyc1();
    chk("post_rst_lvl", 32'(lvl_a), 32'd0);
    clr();
    wait_pa(60);
    chk("rst_press_cnt", c_pa, 1);
    chk("rst_lvl", 32'(lvl_a), 32'd1);
    btn_a = 1'b0;
    clr();
    repeat (40) cyc1();
    chk("drop_rel", c_ra, 1);
    clr();
    repeat (10) begin
      btn_a = 1'b1;
      repeat (15) cyc1();
      btn_a = 1'b0;
      repeat (5) cyc1();
    end
    chk("bounce_press", c_pa, 0);
    chk("bounce_lvl", 32'(lvl_a), 32'd0);
    btn_a = 1'b1;
    clr();
    wait_pa(40);
    chk("stable_press", c_pa, 1);
    clr();
    repeat (150) cyc1();
    chk("rpt_count", c_rpa, 8);
    chk("rpt_nopress", c_pa, 0);
    btn_a = 1'b0;
    clr();
    repeat (40) cyc1();
    chk("rpt_rel", c_ra, 1);
    chk("rpt_rel_lvl", 32'(lvl_a), 32'd0);
    clr();
    repeat (30) cyc1();
    chk("after_rel_rpt", c_rpa, 0);
    btn_a = 1'b1;
    clr();
    wait_pa(40);
    repeat (50) cyc1();
    btn_a = 1'b0;
    clr();
    repeat (20) cyc1();
    chk("align_rel", c_ra, 1);
    chk("align_rpt", c_rpa, 1);
    clr();
    repeat (20) cyc1();
    chk("align_after_rpt", c_rpa, 0);
    btn_a = 1'b1;
    clr();
    wait_pa(40);
    freeze = 1'b1;
    btn_a = 1'b0;
    clr();
    repeat (60) cyc1();
    chk("frz_lvl", 32'(lvl_a), 32'd1);
    chk("frz_rel", c_ra, 0);
    chk("frz_rpt", c_rpa, 0);
    freeze = 1'b0;
    repeat (30) cyc1();
    chk("unfrz_rel", c_ra, 1);
    btn_b = 1'b1;
    repeat (2) cyc1();
    chk("b_lat2", 32'(press_b), 32'd0);
    cyc1();
    chk("b_lat3", 32'(press_b), 32'd1);
    btn_b = 1'b0;
    repeat (5) cyc1();
    clr();
    btn_b = 1'b1;
    cyc1();
    btn_b = 1'b0;
    repeat (5) cyc1();
    chk("b_glitch_press", c_pb, 1);
    chk("b_glitch_lvl", 32'(lvl_b), 32'd0);
    btn_a = 1'b1;
    clr();
    wait_pa(40);
    repeat (60) cyc1();
    rst = 1'b1;
    clr();
    repeat (2) cyc1();
    chk("mid_rst_rel", c_ra, 0);
    chk("mid_rst_lvl", 32'(lvl_a), 32'd0);
    rst = 1'b0;
    clr();
    wait_pa(60);
    chk("re_press", c_pa, 1);
    clr();
    repeat (39) cyc1();
    chk("re_rpt_early", c_rpa, 0);
    cyc1();
    chk("re_rpt_first", c_rpa, 1);
    repeat (150) begin
      btn_a = 1'($urandom_range(0, 1));
      btn_b = 1'($urandom_range(0, 1));
      freeze = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc1();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 40)) cyc1();
    end
    freeze = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
